// File: rtl/tiny16_datapath.sv
// tiny16 datapath: register file (R0 = PC), MAR, word RAM and the shared bus.
// It is the responder to the tiny16 instruction controller and also has a program-load port.
module tiny16_datapath #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [15:0] PC_RESET   = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           ctrl_out,
    input  logic [15:0]           alu_result,
    input  logic                  alu_out_en,
    input  logic                  mem_addr_en,
    input  logic                  mem_in_en,
    input  logic                  mem_out_en,
    input  logic [2:0]            reg_src_sel,
    input  logic [2:0]            reg_dst_sel,
    input  logic                  reg_in_en,
    input  logic                  reg_out_en,
    input  logic                  reg_pc_inc,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [15:0]           ld_data,
    output logic [15:0]           bus,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [15:0]           pc,
    output logic [ADDR_WIDTH-1:0] mar,
    output logic                  bus_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [15:0]           regs [8];
    logic [15:0]           ram  [DEPTH];
    logic [ADDR_WIDTH-1:0] mar_q;
    logic                  bus_err_q;
    logic [15:0]           bus_val;
    logic                  multi_drv;

    // Fixed-priority bus source; ctrl_out is the idle value (immediates, jumps).
    always_comb begin
        bus_val = ctrl_out;
        if (alu_out_en)
            bus_val = alu_result;
        else if (mem_out_en)
            bus_val = ram[mar_q];
        else if (reg_out_en)
            bus_val = regs[reg_src_sel];
    end

    assign multi_drv = (alu_out_en & mem_out_en) |
                       (alu_out_en & reg_out_en) |
                       (mem_out_en & reg_out_en);

    // An explicit R0 write is ordered after the increment so that it takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < 8; i++)
                regs[3'(i)] <= '0;
            regs[0]   <= PC_RESET;
            mar_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (reg_pc_inc)
                regs[0] <= regs[0] + 16'd1;
            if (reg_in_en)
                regs[reg_dst_sel] <= bus_val;
            if (mem_addr_en)
                mar_q <= bus_val[ADDR_WIDTH-1:0];
            if (multi_drv)
                bus_err_q <= 1'b1;
        end
    end

    // The loader works through reset and wins a same-address collision with the bus write.
    always_ff @(posedge clk) begin
        if (!rst && mem_in_en)
            ram[mar_q] <= bus_val;
        if (ld_en)
            ram[ld_addr] <= ld_data;
    end

    assign bus     = bus_val;
    assign alu_a   = regs[reg_dst_sel];
    assign alu_b   = regs[reg_src_sel];
    assign pc      = regs[0];
    assign mar     = mar_q;
    assign bus_err = bus_err_q;

endmodule
